pic_interrupt_sequencer: RTL and testbench

Control sequencer for the 8259-style PIC, built around the rotating priority resolver. It owns the IRR, ISR and lowest-priority pointer, and raises INT toward the CPU. It runs the two-pulse INTA handshake and drives the 8-bit vector on the second acknowledge. It also processes specific, non-specific and automatic EOI, with optional priority rotation.

---
 rtl/pic_pkg.sv | 36 +++
 rtl/rotating_priority_picker.sv | 17 +
 rtl/pic_interrupt_sequencer.sv | 136 +++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt sequencer: handshake states,
// reset constants and the rotating-priority search used by the resolver.
package pic_pkg;

  localparam int         NUM_IR      = 8;
  localparam logic [2:0] RESET_LP    = 3'd7;
  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] level;
  } pick_t;

  // Position of a level in the rotating order: 0 = highest priority, 7 = lp itself.
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  function automatic pick_t highest_set(input logic [7:0] vec, input logic [2:0] lp);
    pick_t      res;
    logic [2:0] lvl;
    res = '{found: 1'b0, level: 3'd0};
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int r = NUM_IR - 1; r >= 0; r--) begin
      lvl = lp + 3'(r) + 3'd1;
      if (vec[lvl]) begin
        res.found = 1'b1;
        res.level = lvl;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rotating_priority_picker.sv
// Returns the highest-priority set bit of req, where level lp+1 ranks highest.
module rotating_priority_picker
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] lp,
  output logic       valid,
  output logic [2:0] level
);

  pick_t w_pick;

  assign w_pick = highest_set(req, lp);
  assign valid  = w_pick.found;
  assign level  = w_pick.level;

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259-style control sequencer: IRR/ISR/priority pointer ownership, the two-pulse
// INTA handshake with vector output, and specific/non-specific/automatic EOI.
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir,
  input  logic [7:0] imr,
  input  logic       ltim,
  input  logic       aeoi,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
  input  logic       inta,
  input  logic       eoi_ns,
  input  logic       eoi_s,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [2:0] active_ir
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_irr, r_isr, r_ir_q, r_data_out;
  logic [2:0] r_lp, r_active_ir;
  logic       r_data_oe, r_spurious;

  logic       w_isr_top_valid, w_cand_valid;
  logic [2:0] w_isr_top_level, w_cand_level, w_eoi_lvl, w_lp_nxt;
  logic       w_eoi_hit, w_ack1, w_ack2, w_grant, w_aeoi_clr;
  logic [7:0] w_isr_eoi, w_above, w_isr_nxt, w_irr_nxt;
  pick_t      w_post_top;

  rotating_priority_picker u_isr_pick (
    .req   (r_isr),
    .lp    (r_lp),
    .valid (w_isr_top_valid),
    .level (w_isr_top_level)
  );

  rotating_priority_picker u_irr_pick (
    .req   (r_irr & ~imr & w_above),
    .lp    (r_lp),
    .valid (w_cand_valid),
    .level (w_cand_level)
  );

  // EOI is resolved first; nesting and the new grant both see the post-EOI ISR.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_eoi_hit = 1'b0;
    w_eoi_lvl = eoi_level;
    if (eoi_s) begin
      w_eoi_hit = r_isr[eoi_level];
    end else if (eoi_ns) begin
      w_eoi_lvl = w_isr_top_level;
      w_eoi_hit = w_isr_top_valid;
    end
    w_isr_eoi  = r_isr & ~(w_eoi_hit ? (8'b1 << w_eoi_lvl) : 8'b0);
    w_post_top = highest_set(w_isr_eoi, r_lp);
    for (int l = 0; l < NUM_IR; l++) begin
      w_above[l] = ~w_post_top.found | (rank(3'(l), r_lp) < rank(w_post_top.level, r_lp));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack1      = 1'b0;
    w_ack2      = 1'b0;
    case (r_state)
      IDLE:    if (w_cand_valid) w_state_nxt = ACK1;
      ACK1:    if (inta) begin
                 w_ack1      = 1'b1;
                 w_state_nxt = ACK2;
               end
      ACK2:    if (inta) begin
                 w_ack2      = 1'b1;
                 w_state_nxt = IDLE;
               end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant    = w_ack1 & w_cand_valid;
    w_aeoi_clr = w_ack2 & aeoi & ~r_spurious & w_isr_eoi[r_active_ir];
    w_isr_nxt  = (w_isr_eoi | (w_grant ? (8'b1 << w_cand_level) : 8'b0))
               & ~(w_aeoi_clr ? (8'b1 << r_active_ir) : 8'b0);
    w_irr_nxt  = (ltim ? ir : (r_irr | (ir & ~r_ir_q)))
               & ~(w_grant ? (8'b1 << w_cand_level) : 8'b0);
    w_lp_nxt   = r_lp;
    if (rotate_on_eoi && w_aeoi_clr) begin
      w_lp_nxt = r_active_ir;
    end else if (rotate_on_eoi && w_eoi_hit) begin
      w_lp_nxt = w_eoi_lvl;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_irr       <= 8'h00;
      r_isr       <= 8'h00;
      r_ir_q      <= 8'h00;
      r_lp        <= RESET_LP;
      r_active_ir <= 3'd0;
      r_spurious  <= 1'b0;
      r_data_out  <= 8'h00;
      r_data_oe   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_irr     <= w_irr_nxt;
      r_isr     <= w_isr_nxt;
      r_ir_q    <= ir;
      r_lp      <= w_lp_nxt;
      r_data_oe <= w_ack2;
      if (w_ack1) begin
        r_active_ir <= w_cand_valid ? w_cand_level : SPURIOUS_IR;
        r_spurious  <= ~w_cand_valid;
      end
      if (w_ack2) r_data_out <= {vector_base, r_active_ir};
    end
  end

  assign int_out   = (r_state == ACK1);
  assign data_out  = r_data_out;
  assign data_oe   = r_data_oe;
  assign irr       = r_irr;
  assign isr       = r_isr;
  assign active_ir = r_active_ir;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Scoreboard bench: the driver steps a behavioural PIC model and queues expected
// responses; an independent monitor compares the DUT against them every cycle.
module tb_pic_interrupt_sequencer;

  logic       clk, reset_n;
  logic [7:0] ir, imr;
  logic       ltim, aeoi, rotate_on_eoi;
  logic [4:0] vector_base;
  logic       inta, eoi_ns, eoi_s;
  logic [2:0] eoi_level;
  logic       int_out, data_oe;
  logic [7:0] data_out, irr, isr;
  logic [2:0] active_ir;

  pic_interrupt_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir            (ir),
    .imr           (imr),
    .ltim          (ltim),
    .aeoi          (aeoi),
    .rotate_on_eoi (rotate_on_eoi),
    .vector_base   (vector_base),
    .inta          (inta),
    .eoi_ns        (eoi_ns),
    .eoi_s         (eoi_s),
    .eoi_level     (eoi_level),
    .int_out       (int_out),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .irr           (irr),
    .isr           (isr),
    .active_ir     (active_ir)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       int_out;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       doe;
    logic [7:0] dout;
    logic [2:0] act;
  } exp_t;

  exp_t       q_exp[$];
  logic [7:0] q_vec[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         done     = 0;

  // Shadow inputs, applied on the next falling edge by tick().
  logic       n_rst = 1'b0;
  logic [7:0] n_ir = 8'h00, n_imr = 8'h00;
  logic       n_ltim = 1'b0, n_aeoi = 1'b0, n_rot = 1'b0;
  logic [4:0] n_base = 5'h08;

  // Behavioural model state.
  logic [7:0] m_irr, m_isr, m_irq, m_dout;
  int         m_lp, m_phase, m_active;
  bit         m_spur, m_doe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_irq = 0; m_dout = 0;
    m_lp = 7; m_phase = 0; m_active = 0; m_spur = 0; m_doe = 0;
  endtask

  task automatic model_step();
    logic [7:0] isr_e, irr_n;
    int old_lp, new_lp, clr, cand, grant, l;
    old_lp = m_lp;
    isr_e  = m_isr;
    clr    = -1;
    if (eoi_s) begin
      if (m_isr[eoi_level]) clr = int'(eoi_level);
    end else if (eoi_ns) begin
      for (int r = 0; r < 8; r++) begin
        l = (old_lp + 1 + r) % 8;
        if (m_isr[l]) begin clr = l; break; end
      end
    end
    new_lp = old_lp;
    if (clr >= 0) begin
      isr_e[clr] = 1'b0;
      if (rotate_on_eoi) new_lp = clr;
    end
    // Scan in priority order; an in-service level blocks itself and everything below it.
    cand = -1;
    for (int r = 0; r < 8; r++) begin
      l = (old_lp + 1 + r) % 8;
      if (isr_e[l]) break;
      if (m_irr[l] && !imr[l]) begin cand = l; break; end
    end
    grant = -1;
    m_doe = 0;
    case (m_phase)
      0: if (cand >= 0) m_phase = 1;
      1: if (inta) begin
           if (cand >= 0) begin
             m_active = cand; isr_e[cand] = 1'b1; grant = cand; m_spur = 0;
           end else begin
             m_active = 7; m_spur = 1;
           end
           m_phase = 2;
         end
      default: if (inta) begin
           m_dout  = {vector_base, 3'(m_active)};
           m_doe   = 1;
           m_phase = 0;
           q_vec.push_back(m_dout);
           if (aeoi && !m_spur && isr_e[m_active]) begin
             isr_e[m_active] = 1'b0;
             if (rotate_on_eoi) new_lp = m_active;
           end
         end
    endcase
    irr_n = ltim ? ir : (m_irr | (ir & ~m_irq));
    if (grant >= 0) irr_n[grant] = 1'b0;
    m_irr = irr_n;
    m_isr = isr_e;
    m_irq = ir;
    m_lp  = new_lp;
  endtask

  task automatic tick(input logic a_inta = 0, input logic a_ns = 0,
                      input logic a_s = 0, input logic [2:0] a_lvl = 0);
    exp_t e;
    @(negedge clk);
    reset_n = n_rst; ir = n_ir; imr = n_imr; ltim = n_ltim; aeoi = n_aeoi;
    rotate_on_eoi = n_rot; vector_base = n_base;
    inta = a_inta; eoi_ns = a_ns; eoi_s = a_s; eoi_level = a_lvl;
    if (!n_rst) model_reset();
    else        model_step();
    e.int_out = (m_phase == 1);
    e.irr = m_irr; e.isr = m_isr; e.doe = m_doe; e.dout = m_dout; e.act = 3'(m_active);
    q_exp.push_back(e);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 0; n_ir = 0; n_imr = 0; n_ltim = 0; n_aeoi = 0; n_rot = 0; n_base = 5'h08;
    tick(); tick();
    sample();
    check("rst_int_out", int_out, 0);
    check("rst_irr", irr, 0);
    check("rst_isr", isr, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_data_out", data_out, 0);
    check("rst_active_ir", active_ir, 0);
    n_rst = 1;
    tick();
  endtask

  task automatic serve(output logic [7:0] vec);
    int k = 0;
    while (!int_out && k < 12) begin
      tick(); sample(); k++;
    end
    check("int_out_wait", int_out, 1);
    tick(1); tick(1); sample();
    check("serve_data_oe", data_oe, 1);
    vec = data_out;
  endtask

  // Monitor: compares every cycle, and pops a vector whenever the DUT drives one.
  initial begin
    exp_t e;
    forever begin
      sample();
      if (done) break;
      if (q_exp.size() == 0) begin
        check("exp_queue_underflow", 1, 0);
        continue;
      end
      e = q_exp.pop_front();
      check("mon_int_out", int_out, e.int_out);
      check("mon_irr", irr, e.irr);
      check("mon_isr", isr, e.isr);
      check("mon_data_oe", data_oe, e.doe);
      check("mon_data_out", data_out, e.dout);
      check("mon_active_ir", active_ir, e.act);
      if (data_oe === 1'b1) begin
        if (q_vec.size() == 0) check("unexpected_data_oe", data_oe, 0);
        else                   check("mon_vector", data_out, q_vec.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] v;
    reset_n = 0; ir = 0; imr = 0; ltim = 0; aeoi = 0; rotate_on_eoi = 0;
    vector_base = 5'h08; inta = 0; eoi_ns = 0; eoi_s = 0; eoi_level = 0;

    // Basic edge-triggered handshake on IR3.
    do_reset();
    n_ir = 8'h08; tick(); sample();
    check("t1_irr", irr, 8'h08);
    check("t1_int_early", int_out, 0);
    tick(); sample();
    check("t1_int_out", int_out, 1);
    tick(1); sample();
    check("t1_isr", isr, 8'h08);
    check("t1_int_drop", int_out, 0);
    tick(1); sample();
    check("t1_vector", data_out, 8'h43);
    check("t1_data_oe", data_oe, 1);
    tick(); sample();
    check("t1_oe_pulse", data_oe, 0);
    check("t1_hold", data_out, 8'h43);

    // Nesting, non-specific and specific EOI.
    do_reset();
    n_ir = 8'h20; serve(v);
    check("t2_vec5", v, 8'h45);
    n_ir = 8'h24; serve(v);
    check("t2_vec2", v, 8'h42);
    check("t2_isr_nested", isr, 8'h24);
    tick(0, 1); sample();
    check("t2_isr_eoi_ns", isr, 8'h20);
    n_ir = 8'h64; repeat (4) tick();
    sample();
    check("t2_blocked", int_out, 0);
    tick(0, 0, 1, 3'd5); tick(); sample();
    check("t2_unblocked", int_out, 1);

    // Rotation on EOI.
    do_reset();
    n_rot = 1; n_ir = 8'hFF; serve(v);
    check("t3_first", v, 8'h40);
    tick(0, 1); serve(v);
    check("t3_second", v, 8'h41);
    tick(0, 1);
    n_ir = 8'h00; tick();
    n_ir = 8'hFF; tick(); serve(v);
    check("t3_rotated", v, 8'h42);

    // Spurious: level request withdrawn before the first acknowledge.
    do_reset();
    n_ltim = 1; n_ir = 8'h10; tick(); tick(); sample();
    check("t4_int_out", int_out, 1);
    n_ir = 8'h00; tick(); tick(1); tick(1); sample();
    check("t4_vector", data_out, 8'h47);
    check("t4_isr", isr, 8'h00);

    // Automatic EOI with rotation.
    do_reset();
    n_aeoi = 1; n_rot = 1; n_ir = 8'h02; serve(v);
    check("t5_vector", v, 8'h41);
    check("t5_isr_cleared", isr, 8'h00);
    n_ir = 8'h07; tick(); serve(v);
    check("t5_rotated", v, 8'h42);

    // Reset in the middle of a handshake.
    do_reset();
    n_ir = 8'h08; tick(); tick(); tick(1);
    n_rst = 0; n_ir = 8'h00; tick();
    #1;
    check("t6_async_int", int_out, 0);
    check("t6_async_isr", isr, 0);
    n_rst = 1; tick(); tick(1); sample();
    check("t6_no_data_oe", data_oe, 0);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) begin
        n_ltim = 1'($urandom); n_aeoi = 1'($urandom); n_rot = 1'($urandom);
        n_base = 5'($urandom);
        n_imr  = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(5, 0) == 0) n_ir = 8'($urandom);
      tick($urandom_range(2, 0) == 0, $urandom_range(9, 0) == 0,
           $urandom_range(9, 0) == 0, 3'($urandom));
    end

    sample();
    #1;
    done = 1;
    check("vec_queue_drained", q_vec.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
